// File: rtl/johnson_step_timebase.sv
// Clock-enable timebase for the Johnson counter: free-running power-of-two divider
// or debounced single-step ticks, toggled by a debounced mode button.
module johnson_step_timebase #(
    parameter int BASE_EXP        = 22,
    parameter int DIV_W           = 27,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       mode_n,
    input  logic       step_n,
    input  logic [1:0] rate,
    output logic       tick,
    output logic       running
);

    // state    | meaning
    // ST_RUN   | divider free-runs, tick on terminal count, step presses ignored
    // ST_PAUSE | divider held at 0, one tick per step press
    typedef enum logic {ST_RUN, ST_PAUSE} state_t;

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    // Button index 0 is mode, index 1 is step.
    logic [1:0]      sync1_q, sync1_d;
    logic [1:0]      sync2_q, sync2_d;
    logic [1:0]      level_q, level_d;
    logic [1:0]      level_dly_q, level_dly_d;
    logic [1:0]      press_q, press_d;
    logic [DB_W-1:0] db_cnt_q [2];
    logic [DB_W-1:0] db_cnt_d [2];

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] div_max;
    logic             tick_q, tick_d;
    logic             running_q, running_d;

    always_comb begin
        sync1_d     = {step_n, mode_n};
        sync2_d     = sync1_q;
        level_d     = level_q;
        level_dly_d = level_q;
        for (int i = 0; i < 2; i++) begin
            db_cnt_d[i] = '0;
            if (sync2_q[i] != level_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    level_d[i] = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
                end
            end
        end
        // Only the falling (press) edge of the accepted level is an event.
        press_d = level_dly_q & ~level_q;
    end

    always_comb begin
        div_max   = (DIV_W'(1) << (BASE_EXP + int'(rate))) - DIV_W'(1);
        state_d   = state_q;
        div_d     = div_q;
        tick_d    = 1'b0;
        if (press_q[0]) begin
            // A toggle never ticks; a coincident step press is dropped.
            state_d = (state_q == ST_RUN) ? ST_PAUSE : ST_RUN;
            div_d   = '0;
        end else if (state_q == ST_RUN) begin
            if (div_q >= div_max) begin
                tick_d = 1'b1;
                div_d  = '0;
            end else begin
                div_d = div_q + DIV_W'(1);
            end
        end else begin
            div_d  = '0;
            tick_d = press_q[1];
        end
        running_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q     <= 2'b11;
            sync2_q     <= 2'b11;
            level_q     <= 2'b11;
            level_dly_q <= 2'b11;
            press_q     <= 2'b00;
            db_cnt_q    <= '{default: '0};
            state_q     <= ST_RUN;
            div_q       <= '0;
            tick_q      <= 1'b0;
            running_q   <= 1'b1;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            level_q     <= level_d;
            level_dly_q <= level_dly_d;
            press_q     <= press_d;
            db_cnt_q    <= db_cnt_d;
            state_q     <= state_d;
            div_q       <= div_d;
            tick_q      <= tick_d;
            running_q   <= running_d;
        end
    end

    assign tick    = tick_q;
    assign running = running_q;

endmodule

// File: tb/tb_johnson_step_timebase.sv
// Self-checking bench for johnson_step_timebase: expected tick cycles are queued
// as stimulus is driven and matched against observed ticks by a monitor.
module tb_johnson_step_timebase;

    logic       clk = 1'b0;
    logic       reset;
    logic       mode_n;
    logic       step_n;
    logic [1:0] rate;
    logic       tick;
    logic       running;

    int cyc    = 0;
    int n_cmp  = 0;
    int n_err  = 0;
    int win_lo = 0;
    int win_hi = 0;
    int exp_q[$];

    johnson_step_timebase #(
        .BASE_EXP(2),
        .DIV_W(8),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .mode_n(mode_n),
        .step_n(step_n),
        .rate(rate),
        .tick(tick),
        .running(running)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Every tick inside the open window must match the oldest queued expectation.
    always @(negedge clk) begin
        if (cyc > win_lo && cyc <= win_hi && tick === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_tick: got tick at cycle %0d, required none", cyc);
            end else begin
                int e;
                e = exp_q.pop_front();
                if (cyc !== e) begin
                    n_err++;
                    $display("FAIL tick_time: got tick at cycle %0d, required cycle %0d", cyc, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by time limit, required finish");
        $fatal(1, "timeout");
    end

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic do_reset(output int r);
        reset  = 1'b1;
        mode_n = 1'b1;
        step_n = 1'b1;
        rate   = 2'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        r = cyc;
    endtask

    task automatic test_reset();
        int r;
        reset  = 1'b1;
        mode_n = 1'b1;
        step_n = 1'b1;
        rate   = 2'd0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (tick !== 1'b0) begin
            n_err++;
            $display("FAIL reset_tick: got %b, required 0", tick);
        end
        n_cmp++;
        if (running !== 1'b1) begin
            n_err++;
            $display("FAIL reset_running: got %b, required 1", running);
        end
        reset = 1'b0;
        r = cyc;
        win_lo = r;
        win_hi = r + 25;
        exp_q.delete();
        exp_q.push_back(r + 4);
        exp_q.push_back(r + 8);
        exp_q.push_back(r + 12);
        // 1-cycle reset at edge r+15; divider restarts from 0
        exp_q.push_back(r + 19);
        exp_q.push_back(r + 23);
        wait_until(r + 14);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_cmp++;
        if (running !== 1'b1) begin
            n_err++;
            $display("FAIL midrun_reset_running: got %b, required 1", running);
        end
        wait_until(win_hi + 1);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL reset_missing_ticks: got %0d unmatched, required 0", exp_q.size());
        end
        win_lo = 0;
        win_hi = 0;
    endtask

    task automatic test_rate_change();
        int r;
        do_reset(r);
        win_lo = r;
        win_hi = r + 103;
        exp_q.delete();
        exp_q.push_back(r + 4);
        exp_q.push_back(r + 8);
        exp_q.push_back(r + 40);
        exp_q.push_back(r + 72);
        exp_q.push_back(r + 93);
        exp_q.push_back(r + 97);
        exp_q.push_back(r + 101);
        wait_until(r + 8);
        rate = 2'd3;
        // divider holds 20 after edge r+92
        wait_until(r + 92);
        rate = 2'd0;
        wait_until(win_hi + 1);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL rate_missing_ticks: got %0d unmatched, required 0", exp_q.size());
        end
        win_lo = 0;
        win_hi = 0;
    endtask

    task automatic test_debounce();
        int r;
        do_reset(r);
        win_lo = r;
        win_hi = r + 60;
        exp_q.delete();
        // toggle edge r+28 coincides with a terminal count and must not tick
        for (int e = r + 4; e < r + 28; e += 4) exp_q.push_back(e);
        wait_until(r + 2);
        mode_n = 1'b0;
        wait_until(r + 5);
        mode_n = 1'b1;
        wait_until(r + 14);
        n_cmp++;
        if (running !== 1'b1) begin
            n_err++;
            $display("FAIL glitch_running: got %b, required 1", running);
        end
        wait_until(r + 20);
        mode_n = 1'b0;
        wait_until(r + 27);
        n_cmp++;
        if (running !== 1'b1) begin
            n_err++;
            $display("FAIL debounce_early_running: got %b, required 1", running);
        end
        wait_until(r + 28);
        n_cmp++;
        if (running !== 1'b0) begin
            n_err++;
            $display("FAIL debounce_toggle_running: got %b, required 0", running);
        end
        wait_until(r + 30);
        mode_n = 1'b1;
        wait_until(win_hi + 1);
        n_cmp++;
        if (running !== 1'b0) begin
            n_err++;
            $display("FAIL debounce_pause_hold: got %b, required 0", running);
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL debounce_missing_ticks: got %0d unmatched, required 0", exp_q.size());
        end
        win_lo = 0;
        win_hi = 0;
    endtask

    task automatic test_single_step();
        int r;
        do_reset(r);
        win_lo = r;
        win_hi = r + 135;
        exp_q.delete();
        exp_q.push_back(r + 4);
        exp_q.push_back(r + 8);
        exp_q.push_back(r + 28);
        exp_q.push_back(r + 48);
        exp_q.push_back(r + 68);
        exp_q.push_back(r + 88);
        wait_until(r + 1);
        mode_n = 1'b0;
        wait_until(r + 7);
        mode_n = 1'b1;
        wait_until(r + 9);
        n_cmp++;
        if (running !== 1'b0) begin
            n_err++;
            $display("FAIL step_pause_entry: got %b, required 0", running);
        end
        for (int k = 0; k < 3; k++) begin
            wait_until(r + 20 + 20 * k);
            step_n = 1'b0;
            wait_until(r + 26 + 20 * k);
            step_n = 1'b1;
        end
        wait_until(r + 80);
        step_n = 1'b0;
        wait_until(r + 120);
        step_n = 1'b1;
        wait_until(win_hi + 1);
        n_cmp++;
        if (running !== 1'b0) begin
            n_err++;
            $display("FAIL step_running: got %b, required 0", running);
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL step_missing_ticks: got %0d unmatched, required 0", exp_q.size());
        end
        win_lo = 0;
        win_hi = 0;
    endtask

    task automatic test_simultaneous();
        int r;
        do_reset(r);
        win_lo = r;
        win_hi = r + 38;
        exp_q.delete();
        exp_q.push_back(r + 4);
        exp_q.push_back(r + 8);
        exp_q.push_back(r + 32);
        exp_q.push_back(r + 36);
        wait_until(r + 1);
        mode_n = 1'b0;
        wait_until(r + 7);
        mode_n = 1'b1;
        wait_until(r + 20);
        mode_n = 1'b0;
        step_n = 1'b0;
        wait_until(r + 26);
        mode_n = 1'b1;
        step_n = 1'b1;
        wait_until(r + 27);
        n_cmp++;
        if (running !== 1'b0) begin
            n_err++;
            $display("FAIL simul_before_running: got %b, required 0", running);
        end
        wait_until(r + 28);
        n_cmp++;
        if (running !== 1'b1) begin
            n_err++;
            $display("FAIL simul_running: got %b, required 1", running);
        end
        wait_until(win_hi + 1);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL simul_missing_ticks: got %0d unmatched, required 0", exp_q.size());
        end
        win_lo = 0;
        win_hi = 0;
    endtask

    task automatic test_held_reset();
        int r;
        mode_n = 1'b0;
        reset  = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        r = cyc;
        win_lo = r;
        win_hi = r + 45;
        exp_q.delete();
        exp_q.push_back(r + 4);
        wait_until(r + 7);
        n_cmp++;
        if (running !== 1'b1) begin
            n_err++;
            $display("FAIL held_early_running: got %b, required 1", running);
        end
        wait_until(r + 8);
        n_cmp++;
        if (running !== 1'b0) begin
            n_err++;
            $display("FAIL held_toggle_running: got %b, required 0", running);
        end
        wait_until(r + 30);
        n_cmp++;
        if (running !== 1'b0) begin
            n_err++;
            $display("FAIL held_single_toggle: got %b, required 0", running);
        end
        mode_n = 1'b1;
        wait_until(win_hi + 1);
        n_cmp++;
        if (running !== 1'b0) begin
            n_err++;
            $display("FAIL held_release_running: got %b, required 0", running);
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL held_missing_ticks: got %0d unmatched, required 0", exp_q.size());
        end
        win_lo = 0;
        win_hi = 0;
    endtask

    initial begin
        reset  = 1'b1;
        mode_n = 1'b1;
        step_n = 1'b1;
        rate   = 2'd0;
        @(negedge clk);
        test_reset();
        test_rate_change();
        test_debounce();
        test_single_step();
        test_simultaneous();
        test_held_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
